// File: rtl/intra_pkg.sv
// Shared types and constants for the intra-prediction block scheduler.
package intra_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        DONE
    } sched_state_t;

    localparam int COORD_W_DEF = 16;
    typedef logic [COORD_W_DEF-1:0] coord_t;

    localparam int BLK_LUMA   = 4;
    localparam int BLK_CHROMA = 8;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intra_prio_enc.sv
// Lowest-index-zero priority encoder: returns {found, index} of the first clear bit.
// Latency: combinational.
// Backpressure: none; found=0 when every bit is set.
module intra_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     bits,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Scan high to low so the lowest clear bit is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!bits[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/intra_mb_scheduler.sv
// Raster-order BLKxBLK block dispatcher to the lowest-index idle intra engine; INTRA_LEFT_DEP_EN adds a left-neighbour stall.
// Latency: start at edge t -> first eng_start high in cycle t+2; one dispatch per cycle at most.
// Backpressure: dispatch waits for an idle engine (busy bit cleared by eng_done).
module intra_mb_scheduler
    import intra_pkg::*;
#(
    parameter int NUM_ENGINES = 2,
    parameter int FRAME_W     = 1280,
    parameter int FRAME_H     = 720,
    parameter int BLK         = 4,
    parameter int COORD_W     = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*COORD_W-1:0] eng_x,
    output logic [NUM_ENGINES*COORD_W-1:0] eng_y,
    output logic                           busy,
    output logic                           frame_done,
    output logic [31:0]                    blocks_issued
);

    localparam int IDX_W = idx_width(NUM_ENGINES);
    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(FRAME_W - BLK);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(FRAME_H - BLK);
    localparam logic [COORD_W-1:0] STEP   = COORD_W'(BLK);

    sched_state_t           state, state_nxt;
    logic [NUM_ENGINES-1:0] eng_busy;
    logic [NUM_ENGINES-1:0] disp_vec;
    logic [COORD_W-1:0]     cur_x, cur_y;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;
    logic                   dep_stall;
    logic                   dispatch;
    logic                   last_blk;

    intra_prio_enc #(
        .N     (NUM_ENGINES),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .bits  (eng_busy),
        .found (free_found),
        .index (free_idx)
    );

`ifdef INTRA_LEFT_DEP_EN
    // In raster order the left neighbour is always the previous dispatch.
    logic [IDX_W-1:0] prev_eng;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_eng <= '0;
        end else if (dispatch) begin
            prev_eng <= free_idx;
        end
    end

    assign dep_stall = (cur_x != '0) && eng_busy[prev_eng];
`else
    assign dep_stall = 1'b0;
`endif

    assign dispatch   = (state == DISPATCH) && free_found && !dep_stall;
    assign last_blk   = (cur_x == LAST_X) && (cur_y == LAST_Y);
    assign disp_vec   = dispatch ? (NUM_ENGINES'(1) << free_idx) : '0;
    assign busy       = (state == DISPATCH) || (state == DRAIN);
    assign frame_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = DISPATCH;
            DISPATCH: if (dispatch && last_blk) state_nxt = DRAIN;
            DRAIN:    if (eng_busy == '0) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            eng_busy      <= '0;
            eng_start     <= '0;
            eng_x         <= '0;
            eng_y         <= '0;
            cur_x         <= '0;
            cur_y         <= '0;
            blocks_issued <= '0;
        end else begin
            state     <= state_nxt;
            eng_start <= disp_vec;
            // A dispatch to the same engine wins over a coincident eng_done.
            eng_busy  <= (eng_busy & ~eng_done) | disp_vec;

            if (state == IDLE && start) begin
                cur_x         <= '0;
                cur_y         <= '0;
                blocks_issued <= '0;
            end

            if (dispatch) begin
                eng_x[int'(free_idx)*COORD_W +: COORD_W] <= cur_x;
                eng_y[int'(free_idx)*COORD_W +: COORD_W] <= cur_y;
                blocks_issued <= blocks_issued + 32'd1;
                if (last_blk) begin
                    cur_x <= '0;
                    cur_y <= '0;
                end else if (cur_x == LAST_X) begin
                    cur_x <= '0;
                    cur_y <= cur_y + STEP;
                end else begin
                    cur_x <= cur_x + STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_intra_mb_scheduler.sv
// Bench for intra_mb_scheduler on a 16x8 plane with 4x4 blocks, checked against a block-index reference model.
module tb_intra_mb_scheduler;

    localparam int FW  = 16;
    localparam int FH  = 8;
    localparam int BLK = 4;
    localparam int CW  = 16;
`ifdef INTRA_LEFT_DEP_EN
    localparam int N      = 4;
    localparam int NR_EXP = 1;
`else
    localparam int N      = 2;
    localparam int NR_EXP = 2;
`endif
    localparam int BW    = FW / BLK;
    localparam int TOTAL = BW * (FH / BLK);

    logic          clk;
    logic          reset;
    logic          start;
    logic [N-1:0]  eng_done;
    logic [N-1:0]  eng_start;
    logic [N*CW-1:0] eng_x;
    logic [N*CW-1:0] eng_y;
    logic          busy;
    logic          frame_done;
    logic [31:0]   blocks_issued;

    intra_mb_scheduler #(
        .NUM_ENGINES (N),
        .FRAME_W     (FW),
        .FRAME_H     (FH),
        .BLK         (BLK),
        .COORD_W     (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .eng_done      (eng_done),
        .eng_start     (eng_start),
        .eng_x         (eng_x),
        .eng_y         (eng_y),
        .busy          (busy),
        .frame_done    (frame_done),
        .blocks_issued (blocks_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    st;
        logic [N*CW-1:0] x;
        logic [N*CW-1:0] y;
        logic [31:0]     iss;
        logic            bsy;
        logic            fd;
    } snap_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    snap_t obs_tr[$];
    snap_t exp_tr[$];
    int delay[N];
    int due[N];

    // Reference model: phase 0 idle, 1 issuing, 2 waiting for engines, 3 done pulse.
    // m_k is the raster index of the next block, which is also the issued count.
    int              m_phase;
    bit [N-1:0]      m_busy;
    int              m_k;
    int              m_prev;
    logic [N*CW-1:0] m_x;
    logic [N*CW-1:0] m_y;
    logic [N-1:0]    m_st;

    function automatic snap_t model_out();
        return {m_st, m_x, m_y, 32'(m_k), (m_phase == 1 || m_phase == 2), (m_phase == 3)};
    endfunction

    function automatic int low_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_tick(input bit r, input bit s, input logic [N-1:0] d);
        bit [N-1:0] ns;
        int nph;
        int pick;
        bit stall;
        if (r) begin
            m_phase = 0; m_busy = '0; m_k = 0; m_prev = 0;
            m_x = '0; m_y = '0; m_st = '0;
        end else begin
            ns = '0;
            nph = m_phase;
            case (m_phase)
                0: if (s) begin nph = 1; m_k = 0; end
                1: begin
                    pick = -1;
                    for (int i = N - 1; i >= 0; i--) if (!m_busy[i]) pick = i;
                    stall = 1'b0;
`ifdef INTRA_LEFT_DEP_EN
                    if ((m_k % BW) != 0 && m_busy[m_prev]) stall = 1'b1;
`endif
                    if (pick >= 0 && !stall) begin
                        ns[pick] = 1'b1;
                        m_x[pick*CW +: CW] = CW'((m_k % BW) * BLK);
                        m_y[pick*CW +: CW] = CW'((m_k / BW) * BLK);
                        m_prev = pick;
                        m_k++;
                        if (m_k == TOTAL) nph = 2;
                    end
                end
                2: if (m_busy == '0) nph = 3;
                default: nph = 0;
            endcase
            m_busy  = (m_busy & ~d) | ns;
            m_st    = ns;
            m_phase = nph;
        end
    endtask

    // One clock: record DUT and model, let the engine stubs react, drive inputs.
    task automatic step(input bit r, input bit s, input logic [N-1:0] extra);
        logic [N-1:0] d;
        @(negedge clk);
        obs_tr.push_back({eng_start, eng_x, eng_y, blocks_issued, busy, frame_done});
        exp_tr.push_back(model_out());
        d = extra;
        for (int i = 0; i < N; i++) begin
            if (eng_start[i] && delay[i] >= 0) due[i] = cyc + delay[i];
            if (due[i] == cyc) d[i] = 1'b1;
        end
        reset    = r;
        start    = s;
        eng_done = d;
        model_tick(r, s, d);
        cyc++;
    endtask

    task automatic clear_trace();
        obs_tr.delete();
        exp_tr.delete();
    endtask

    task automatic test_reset();
        clear_trace();
        for (int k = 0; k < 3; k++) step(0, 0, '0);
        for (int k = 0; k < obs_tr.size(); k++) begin
            total++;
            if (obs_tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL reset_trace cyc%0d got %h want %h", k, obs_tr[k], exp_tr[k]);
            end
        end
        total++;
        if ({eng_start, eng_x, eng_y, busy, frame_done, blocks_issued} !== '0) begin
            bad++;
            $display("FAIL reset_values got st=%h x=%h y=%h busy=%b fd=%b iss=%0d want all zero",
                     eng_start, eng_x, eng_y, busy, frame_done, blocks_issued);
        end
    endtask

    task automatic test_frame_fixed();
        int fd;
        int n;
        int idx;
        snap_t o;
        clear_trace();
        for (int i = 0; i < N; i++) begin delay[i] = 3; due[i] = -1; end
        step(0, 1, '0);
        fd = 0;
        for (int k = 0; k < 300 && !(fd > 0 && m_phase == 0); k++) begin
            step(0, 0, '0);
            if (obs_tr[obs_tr.size()-1].fd) fd++;
        end
        step(0, 0, '0);
        for (int k = 0; k < obs_tr.size(); k++) begin
            total++;
            if (obs_tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL frame_trace cyc%0d got %h want %h", k, obs_tr[k], exp_tr[k]);
            end
        end
        total++;
        if (obs_tr[2].st !== N'(1)) begin
            bad++;
            $display("FAIL first_latency eng_start at start+2 got %b want %b", obs_tr[2].st, N'(1));
        end
        n = 0;
        foreach (obs_tr[k]) begin
            o = obs_tr[k];
            if (o.st != '0) begin
                idx = low_idx(o.st);
                total++;
                if (o.x[idx*CW +: CW] !== CW'((n % BW) * BLK) || o.y[idx*CW +: CW] !== CW'((n / BW) * BLK)) begin
                    bad++;
                    $display("FAIL raster_order blk%0d got (%0d,%0d) want (%0d,%0d)", n,
                             o.x[idx*CW +: CW], o.y[idx*CW +: CW], (n % BW) * BLK, (n / BW) * BLK);
                end
                n++;
            end
        end
        total++;
        if (fd !== 1 || n !== TOTAL || blocks_issued !== 32'(TOTAL) || busy !== 1'b0) begin
            bad++;
            $display("FAIL frame_summary got fd=%0d blocks=%0d iss=%0d busy=%b want 1/%0d/%0d/0",
                     fd, n, blocks_issued, busy, TOTAL, TOTAL);
        end
    endtask

    task automatic test_no_reply();
        int n;
        int fd;
        clear_trace();
        for (int i = 0; i < N; i++) begin delay[i] = -1; due[i] = -1; end
        step(0, 1, '0);
        n = 0;
        fd = 0;
        for (int k = 0; k < 40; k++) begin
            step(0, 0, '0);
            if (obs_tr[obs_tr.size()-1].st != '0) n++;
            if (obs_tr[obs_tr.size()-1].fd) fd++;
        end
        for (int k = 0; k < obs_tr.size(); k++) begin
            total++;
            if (obs_tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL noreply_trace cyc%0d got %h want %h", k, obs_tr[k], exp_tr[k]);
            end
        end
        total++;
        if (n !== NR_EXP || fd !== 0 || busy !== 1'b1 || blocks_issued !== 32'(NR_EXP)) begin
            bad++;
            $display("FAIL noreply_stall got starts=%0d fd=%0d busy=%b iss=%0d want %0d/0/1/%0d",
                     n, fd, busy, blocks_issued, NR_EXP, NR_EXP);
        end
    endtask

    task automatic test_simul_done();
        int fd;
        clear_trace();
        step(0, 0, '1);
        for (int i = 0; i < N; i++) delay[i] = 2;
        fd = 0;
        for (int k = 0; k < 300 && !(fd > 0 && m_phase == 0); k++) begin
            step(0, 0, '0);
            if (obs_tr[obs_tr.size()-1].fd) fd++;
        end
        for (int k = 0; k < obs_tr.size(); k++) begin
            total++;
            if (obs_tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL simul_trace cyc%0d got %h want %h", k, obs_tr[k], exp_tr[k]);
            end
        end
`ifndef INTRA_LEFT_DEP_EN
        total++;
        if (obs_tr[2].st !== 2'b01 || obs_tr[3].st !== 2'b10) begin
            bad++;
            $display("FAIL simul_redispatch got %b,%b want 01,10", obs_tr[2].st, obs_tr[3].st);
        end
`endif
        total++;
        if (fd !== 1) begin
            bad++;
            $display("FAIL simul_frame_done got %0d pulses want 1", fd);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int fd;
        int idx;
        snap_t o;
        clear_trace();
        for (int i = 0; i < N; i++) begin delay[i] = 3; due[i] = -1; end
        step(0, 1, '0);
        n = 0;
        for (int k = 0; k < 100 && n < 5; k++) begin
            step(0, 0, '0);
            if (obs_tr[obs_tr.size()-1].st != '0) n++;
        end
        total++;
        if (n !== 5) begin
            bad++;
            $display("FAIL midreset_reach got %0d dispatches want 5", n);
        end
        step(1, 0, '0);
        step(0, 0, '1);
        step(0, 0, '0);
        total++;
        if ({eng_start, eng_x, eng_y, busy, frame_done, blocks_issued} !== '0) begin
            bad++;
            $display("FAIL midreset_values got st=%h x=%h y=%h busy=%b fd=%b iss=%0d want all zero",
                     eng_start, eng_x, eng_y, busy, frame_done, blocks_issued);
        end
        step(0, 1, '0);
        step(0, 0, '0);
        step(0, 0, '0);
        o = obs_tr[obs_tr.size()-1];
        idx = low_idx(o.st);
        total++;
        if (idx !== 0 || o.x[CW-1:0] !== '0 || o.y[CW-1:0] !== '0 || o.iss !== 32'd1) begin
            bad++;
            $display("FAIL midreset_restart got eng=%0d (%0d,%0d) iss=%0d want eng0 (0,0) iss=1",
                     idx, o.x[CW-1:0], o.y[CW-1:0], o.iss);
        end
        fd = 0;
        for (int k = 0; k < 300 && !(fd > 0 && m_phase == 0); k++) begin
            step(0, 0, '0);
            if (obs_tr[obs_tr.size()-1].fd) fd++;
        end
        for (int k = 0; k < obs_tr.size(); k++) begin
            total++;
            if (obs_tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL midreset_trace cyc%0d got %h want %h", k, obs_tr[k], exp_tr[k]);
            end
        end
    endtask

    task automatic test_start_in_drain();
        int fd;
        int pulses;
        clear_trace();
        for (int i = 0; i < N; i++) begin delay[i] = 6; due[i] = -1; end
        step(0, 1, '0);
        fd = 0;
        pulses = 0;
        for (int k = 0; k < 300 && !(fd > 0 && m_phase == 0); k++) begin
            if (m_phase == 2 && pulses < 2) begin
                step(0, 1, '0);
                pulses++;
            end else begin
                step(0, 0, '0);
            end
            if (obs_tr[obs_tr.size()-1].fd) fd++;
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, '0);
            if (obs_tr[obs_tr.size()-1].fd) fd++;
        end
        for (int k = 0; k < obs_tr.size(); k++) begin
            total++;
            if (obs_tr[k] !== exp_tr[k]) begin
                bad++;
                $display("FAIL drain_trace cyc%0d got %h want %h", k, obs_tr[k], exp_tr[k]);
            end
        end
        total++;
        if (pulses !== 2 || fd !== 1 || blocks_issued !== 32'(TOTAL) || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain_start got pulses=%0d fd=%0d iss=%0d busy=%b want 2/1/%0d/0",
                     pulses, fd, blocks_issued, busy, TOTAL);
        end
    endtask

    task automatic test_random();
        int fd;
        logic [N-1:0] noise;
        for (int f = 0; f < 3; f++) begin
            clear_trace();
            for (int i = 0; i < N; i++) due[i] = -1;
            step(0, 1, '0);
            fd = 0;
            for (int k = 0; k < 400 && !(fd > 0 && m_phase == 0); k++) begin
                for (int i = 0; i < N; i++) delay[i] = int'($urandom_range(0, 7));
                noise = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
                step(0, ($urandom_range(0, 7) == 0), noise);
                if (obs_tr[obs_tr.size()-1].fd) fd++;
            end
            step(0, 0, '0);
            for (int k = 0; k < obs_tr.size(); k++) begin
                total++;
                if (obs_tr[k] !== exp_tr[k]) begin
                    bad++;
                    $display("FAIL random%0d_trace cyc%0d got %h want %h", f, k, obs_tr[k], exp_tr[k]);
                end
            end
            total++;
            if (fd !== 1) begin
                bad++;
                $display("FAIL random%0d_frame_done got %0d pulses want 1", f, fd);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        eng_done = '0;
        for (int i = 0; i < N; i++) begin delay[i] = -1; due[i] = -1; end
        model_tick(1, 0, '0);
        step(1, 0, '0);
        step(1, 0, '0);
        test_reset();
        test_frame_fixed();
        test_no_reply();
        test_simul_done();
        test_reset_mid();
        test_start_in_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intra_mb_scheduler.md
Name: intra_mb_scheduler

Overview:
- Parametrised raster-order block dispatcher for the intra-prediction engines.
- Walks one colour-component plane in blocks of BLK x BLK pixels and hands each block's (x, y) pixel coordinate to the lowest-index idle engine out of NUM_ENGINES.
- Tracks each engine's completion pulse and reports frame completion once every block is issued and all engines are idle.
- One instance is used per component: luma BLK=4; chroma Cb/Cr BLK=8.

Parameters:
- NUM_ENGINES, 2, number of intra engines served (1..8).
- FRAME_W, 1280, plane width in pixels; must be a multiple of BLK.
- FRAME_H, 720, plane height in pixels; must be a multiple of BLK.
- BLK, 4, block edge in pixels; power of two.
- COORD_W, 16, coordinate width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; ignored unless state is IDLE.
- eng_done  in  NUM_ENGINES  per-engine one-cycle completion pulse.
- eng_start  out  NUM_ENGINES  per-engine one-cycle dispatch pulse.
- eng_x  out  NUM_ENGINES*COORD_W  per-engine block x in pixels; engine i uses slice [i*COORD_W +: COORD_W].
- eng_y  out  NUM_ENGINES*COORD_W  per-engine block y in pixels; same slicing as eng_x.
- busy  out  1  high in DISPATCH and DRAIN.
- frame_done  out  1  one-cycle pulse when the frame completes.
- blocks_issued  out  32  count of blocks dispatched in the current frame.

Behaviour:
- Reset (synchronous): state=IDLE; eng_start=0; eng_x=eng_y=0; busy=0; frame_done=0; blocks_issued=0; all engine-busy bits=0; next coordinate=(0,0).
- Reset asserted mid-frame: same values next edge; in-flight engines are forgotten; a later eng_done is ignored.
- States:
  - IDLE: start -> DISPATCH; next coordinate=(0,0); blocks_issued=0.
  - DISPATCH: at most one dispatch per cycle.
  - DRAIN: wait until all engine-busy bits=0, then -> DONE.
  - DONE: frame_done=1 for exactly one cycle, then -> IDLE.
- Dispatch condition (DISPATCH state): at least one engine-busy bit is 0. The chosen engine is the lowest index with busy bit 0.
- Dispatch actions, all registered so visible the next cycle:
  - eng_start[i]=1 for one cycle; eng_x/eng_y slice i = current coordinate.
  - Busy bit i set; blocks_issued increments.
- eng_x/eng_y slice i holds its value until the next dispatch to engine i.
- Latency: start sampled at edge t -> state DISPATCH after t. The first eng_start is high in the cycle after the first DISPATCH cycle: start at t, eng_start[0] high during cycle t+2.
- Coordinate advance after each dispatch:
  - x += BLK.
  - If x was FRAME_W-BLK: x=0 and y += BLK.
  - If the dispatched block was (FRAME_W-BLK, FRAME_H-BLK): -> DRAIN.
- Arithmetic is unsigned COORD_W; coordinates never exceed FRAME_W-BLK / FRAME_H-BLK.
- eng_done[i] clears busy bit i at the edge.
  - A freed engine is eligible in the following cycle, not in the same cycle.
  - Simultaneous eng_done on several engines: all are cleared.
  - eng_done on an engine that is not busy: ignored.
  - eng_done in the same cycle as that engine's dispatch edge: the dispatch wins and the busy bit stays set.
- start while busy or in DONE: ignored.
- Total blocks per frame = (FRAME_W/BLK)*(FRAME_H/BLK).

Optional Feature:
- Macro: INTRA_LEFT_DEP_EN.
- With the macro: a block with x!=0 is not dispatched until the engine holding its left neighbour has returned eng_done. Because order is raster, the left neighbour is always the previously dispatched block. The scheduler keeps a register prev_eng and stalls while busy[prev_eng]=1. Blocks with x=0 are exempt.
- Without the macro: no dependency stall; dispatch occurs whenever any engine is idle.

Decomposition:
- Shared package intra_pkg holds:
  - state enum typedef sched_state_t {IDLE, DISPATCH, DRAIN, DONE};
  - coordinate typedef coord_t sized by COORD_W;
  - BLK_LUMA=4 and BLK_CHROMA=8 constants.
- One sub-module is natural: intra_prio_enc, a parametrised lowest-index-zero priority encoder returning {found, index}.

Test Plan (FRAME_W=16, FRAME_H=8, BLK=4, NUM_ENGINES=2 unless noted):
- Engines reply 3 cycles after eng_start -> dispatch order (0,0),(4,0),(8,0),(12,0),(0,4),(4,4),(8,4),(12,4); blocks_issued=8; one frame_done pulse; busy low after.
- Engines never reply -> exactly 2 eng_start pulses (engines 0,1 at (0,0),(4,0)); state stays DISPATCH; no frame_done.
- eng_done[0] and eng_done[1] in the same cycle -> both freed; engine 0 dispatched the next cycle, engine 1 the cycle after.
- reset asserted after the 5th dispatch -> outputs at reset values; stray eng_done ignored; a new start restarts at (0,0).
- start pulsed during DRAIN -> ignored; a single frame_done; blocks_issued=8.
- INTRA_LEFT_DEP_EN, NUM_ENGINES=4, engine 0 delays 10 cycles -> (4,0) is not dispatched until 1 cycle after eng_done[0]; (0,4) is not held by any (x,0) block's dependency.
